// File: rtl/lru_state_array.sv
// lru_state_array: per-set 4-way true-LRU state storage with query/touch/allocate sequencing
module lru_state_array #(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [SET_W-1:0] req_set,
    input  logic [1:0]       req_way,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [SET_W-1:0] resp_set,
    output logic [1:0]       resp_victim,
    output logic [5:0]       resp_state
);
    localparam logic [5:0] CANON = 6'h24;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nx;
    logic [SET_W-1:0] cnt, cnt_nx;
    logic [5:0]       mem [NUM_SETS];
    logic [5:0]       rd, eff, upd;
    logic             ok, accept;

    // Move way w to MRU; a touch of the implicit MRU leaves the ordering alone
    function automatic logic [5:0] touch(input logic [5:0] s, input logic [1:0] w);
        logic [1:0] a, b, c, m;
        a = s[5:4];
        b = s[3:2];
        c = s[1:0];
        m = a ^ b ^ c;
        return (w == a) ? {m, b, c} : (w == b) ? {m, a, c} : (w == c) ? {m, a, b} : s;
    endfunction

    // Combinational read, sanitise, and apply the requested op
    always_comb begin
        rd     = mem[req_set];
        ok     = (rd[5:4] != rd[3:2]) && (rd[5:4] != rd[1:0]) && (rd[3:2] != rd[1:0]);
        eff    = ok ? rd : CANON;
        upd    = (req_op == 2'b01) ? touch(eff, req_way) :
                 (req_op == 2'b10) ? touch(eff, eff[1:0]) : eff;
        req_ready = (state == RUN) && (!resp_valid || resp_ready);
        accept = req_valid && req_ready;
    end

    // INIT walks every set once, then hands over to RUN
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (state == INIT) begin
            cnt_nx = cnt + 1'b1;
            if (cnt == SET_W'(NUM_SETS - 1)) state_nx = RUN;
        end
    end

    // FSM state and init counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Array writes: canonical fill during INIT, write-back only when the word changes
    always_ff @(posedge clk) begin
        if (state == INIT) mem[cnt] <= CANON;
        else if (accept && upd != rd) mem[req_set] <= upd;
    end

    // Response register: load on accept, clear on drain without a new accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_set    <= '0;
            resp_victim <= '0;
            resp_state  <= '0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_set    <= req_set;
            resp_victim <= eff[1:0];
            resp_state  <= upd;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lru_state_array.sv
// tb_lru_state_array: scoreboard bench for the LRU state array
module tb_lru_state_array;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       req_valid = 0;
    logic       req_ready;
    logic [1:0] req_op = 0;
    logic [2:0] req_set = 0;
    logic [1:0] req_way = 0;
    logic       resp_valid;
    logic       resp_ready = 1;
    logic [2:0] resp_set;
    logic [1:0] resp_victim;
    logic [5:0] resp_state;

    typedef struct packed {
        logic [2:0] s;
        logic [1:0] v;
        logic [5:0] st;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] model [8];
    int         pass_cnt = 0;
    int         total_cnt = 0;

    lru_state_array dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_set(req_set), .req_way(req_way),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_set(resp_set),
        .resp_victim(resp_victim), .resp_state(resp_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [5:0] m_sanitise(input logic [5:0] s);
        logic [1:0] o [4];
        o[1] = s[5:4];
        o[2] = s[3:2];
        o[3] = s[1:0];
        for (int i = 1; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (o[i] == o[j]) return 6'h24;
        return s;
    endfunction

    // Ordering list MRU..LRU; touched way moves to the front
    function automatic logic [5:0] m_touch(input logic [5:0] s, input logic [1:0] w);
        logic [1:0] o [4];
        int idx;
        o[1] = s[5:4];
        o[2] = s[3:2];
        o[3] = s[1:0];
        o[0] = o[1] ^ o[2] ^ o[3];
        idx = 0;
        for (int i = 0; i < 4; i++) if (o[i] == w) idx = i;
        for (int i = 3; i > 0; i--) if (i <= idx) o[i] = o[i-1];
        o[0] = w;
        return {o[1], o[2], o[3]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) model[i] = 6'h24;
        sb.delete();
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [2:0] s, input logic [1:0] w);
        logic [5:0] e, n;
        e = m_sanitise(model[s]);
        n = (op == 2'b01) ? m_touch(e, w) : (op == 2'b10) ? m_touch(e, e[1:0]) : e;
        model[s] = n;
        sb.push_back('{s: s, v: e[1:0], st: n});
    endtask

    task automatic send(input logic [1:0] op, input logic [2:0] s, input logic [1:0] w);
        int n = 0;
        req_valid = 1;
        req_op    = op;
        req_set   = s;
        req_way   = w;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", req_ready, 1);
        if (req_ready) push_exp(op, s, w);
        @(posedge clk);
        #1;
        req_valid = 0;
    endtask

    task automatic init_check();
        for (int i = 0; i < 8; i++) begin
            check("init_ready_low", req_ready, 0);
            @(posedge clk);
            #1;
        end
        check("init_ready_high", req_ready, 1);
    endtask

    task automatic drain();
        int n = 0;
        resp_ready = 1;
        while ((sb.size() != 0 || resp_valid) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    // Response monitor: pop one expectation per completed handshake
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb.size() == 0) check("unexpected_resp", resp_valid, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                check("resp_set", resp_set, e.s);
                check("resp_victim", resp_victim, e.v);
                check("resp_state", resp_state, e.st);
            end
        end
    end

    initial begin
        model_reset();
        #23;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_set", resp_set, 0);
        check("rst_resp_victim", resp_victim, 0);
        check("rst_resp_state", resp_state, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1;
        init_check();
        for (int i = 0; i < 8; i++) send(2'b00, 3'(i), 0);
        send(2'b10, 3, 0);
        send(2'b00, 3, 0);
        send(2'b01, 3, 2);
        send(2'b01, 3, 2);
        send(2'b00, 3, 0);
        send(2'b01, 3, 0);
        send(2'b11, 3, 1);
        drain();
        resp_ready = 0;
        send(2'b00, 1, 0);
        req_valid = 1;
        req_op    = 2'b00;
        req_set   = 2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_ready", req_ready, 0);
            check("stall_valid", resp_valid, 1);
            check("stall_set", resp_set, 1);
            check("stall_state", resp_state, model[1]);
        end
        @(posedge clk);
        #1;
        resp_ready = 1;
        send(2'b00, 2, 0);
        drain();
        dut.mem[5] <= 6'h00;
        model[5] = 6'h00;
        #1;
        send(2'b01, 5, 1);
        send(2'b00, 5, 0);
        for (int i = 0; i < 40; i++)
            send(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
        drain();
        resp_ready = 0;
        send(2'b10, 6, 0);
        @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        check("midrst_valid", resp_valid, 0);
        check("midrst_ready", req_ready, 0);
        model_reset();
        resp_ready = 1;
        @(negedge clk);
        rst_n = 1;
        init_check();
        for (int i = 0; i < 8; i++) send(2'b00, 3'(i), 0);
        drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
